// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID pipeline register type for the fetch stage.
package fetch_pkg;

    localparam int N       = 64;
    localparam int IMEM_AW = 7;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h8b1f03ff;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [N-1:0]       pc;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a bubble load beats hold, and hold beats a normal load.
import fetch_pkg::*;

module if_id_reg (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and the IF/ID register.
// Optional FETCH_PERF_EN adds fetch_cnt / bubble_cnt performance counters.
import fetch_pkg::*;

module fetch_stage (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_taken,
    input  logic [N-1:0]       br_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [N-1:0]       if_id_pc,
    output logic               if_id_valid,
    output logic               pc_oor
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    logic [N-1:0] pc;
    logic [N-1:0] next_pc;
    logic         load_bubble;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    // Control: a redirect overrides everything; stall freezes both PC and IF/ID
    // unless a bubble is being loaded, in which case only the PC holds.
    assign load_bubble = br_taken | flush;

    always_comb begin
        next_pc = pc + 64'd4;
        if (br_taken) begin
            next_pc = br_target;
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

    // Byte-offset bits are dropped; the index wraps past the end of the ROM.
    assign imem_addr = pc[IMEM_AW+1:2];
    assign pc_oor    = (|pc[N-1:IMEM_AW+2]) | (|pc[1:0]);

    assign if_id_d = '{instr: imem_q, pc: pc, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (load_bubble),
        .hold    (stall),
        .d       (if_id_d),
        .q       (if_id_q)
    );

    assign if_id_instr = if_id_q.instr;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (load_bubble) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end else if (!stall) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage ARM64 pipeline. Holds the program counter, drives the word address into the combinational instruction ROM, and registers the returned instruction with its PC into the IF/ID pipeline register. Handles hazard-unit stalls, taken-branch redirects from MEM, and flush bubbles for the decode stage downstream.

## Interface
- N, 64: PC and address width.
- IMEM_AW, 7: instruction ROM word-address width; the ROM holds 128 words.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold the PC and IF/ID register (load-use hazard).
- flush  input  1  load a bubble into IF/ID.
- br_taken  input  1  taken-branch redirect from MEM.
- br_target  input  N  redirect byte address.
- imem_addr  output  IMEM_AW  ROM word address, PC[IMEM_AW+1:2].
- imem_q  input  32  ROM data; combinational from imem_addr.
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  N  registered PC of if_id_instr.
- if_id_valid  output  1  IF/ID holds a real instruction.
- pc_oor  output  1  PC is outside the ROM: PC[N-1:IMEM_AW+2] != 0, or PC[1:0] != 0.

## Operation
- The PC register drives imem_addr combinationally. imem_q is sampled at the same edge that updates the PC.
- Next-PC priority, highest first:
  - If br_taken, PC <= br_target.
  - Else if stall, PC holds.
  - Else PC <= PC + 4, computed in N bits.
- IF/ID update priority, highest first:
  - If br_taken or flush, load a bubble: instr=NOP (32'h8b1f03ff), pc=0, valid=0.
  - Else if stall, hold.
  - Else load instr=imem_q, pc=PC, valid=1.
- A misaligned br_target is loaded unchanged. pc_oor asserts. The address bits PC[1:0] are ignored for imem_addr.
- PC + 4 from 2^IMEM_AW*4 - 4 gives imem_addr = 0 and asserts pc_oor. The ROM index wraps, and no other action is taken.
- pc_oor is combinational from the PC. It does not suppress fetch; the pipeline's halt or trap logic consumes it.

## Timing
- Reset (asynchronous assert, synchronous to clk on release):
  - PC=0, imem_addr=0.
  - if_id_instr=32'h8b1f03ff, if_id_pc=0, if_id_valid=0.
  - pc_oor=0.
- Fetch latency: the instruction at PC appears on if_id_* one edge after PC is presented. Throughput is one instruction per cycle when not stalled.
- Redirect sampled at edge k: after k, PC=br_target and IF/ID holds a bubble. The target instruction is in IF/ID after edge k+1. Branch penalty is the bubble plus whatever MEM flushes upstream.
- stall and flush together: IF/ID takes a bubble and the PC holds.
- Stall held for M cycles: PC and IF/ID are frozen for M edges. Fetch resumes on the first edge with stall low.
- Reset mid-stall or mid-redirect: reset wins immediately, and pending requests are discarded.

## Configuration
- FETCH_PERF_EN defined: the block adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every edge that loads valid=1.
  - bubble_cnt increments on every edge that loads a bubble.
  - Both counters wrap at 2^32 and hold during stall.
- FETCH_PERF_EN undefined: the counter ports and logic are absent, and the block is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h8b1f03ff.
  - INSTR_W = 32.
  - the if_id_t struct {instr, pc, valid}.
  - the bubble constant of type if_id_t.
- Sub-module if_id_reg: the hold/flush/load register of type if_id_t, with asynchronous reset. fetch_stage instantiates it beside the PC logic and the next-PC mux.

## Test plan
- Reset release, no stall, ROM[0]=f8000001, ROM[1]=f8008002:
  - Before the first edge, imem_addr=0 and valid=0.
  - Edge 1: instr=f8000001, pc=0, valid=1.
  - Edge 2: instr=f8008002, pc=4, imem_addr=2.
- Stall for 2 cycles with PC=0x10: imem_addr stays 4 and the IF/ID contents are unchanged for both edges. The next edge loads the instruction at 0x10.
- br_taken with target 0x20 while PC=0x30:
  - Next edge: imem_addr=8 and a bubble (valid=0, instr=8b1f03ff).
  - Following edge: pc=0x20, valid=1.
- br_taken, stall and flush asserted together with target 0x40: PC=0x40 and IF/ID holds a bubble (redirect wins).
- PC=0x1FC, free-running: the next edge gives PC=0x200, imem_addr=0 and pc_oor=1. A redirect to 0x0 clears pc_oor. Separately, br_target=0x22 sets pc_oor=1.
- With FETCH_PERF_EN: 10 run cycles, 1 flush and 2 stall cycles from reset must end with fetch_cnt=10 and bubble_cnt=1. An asynchronous reset_n pulse mid-run zeroes both counters and the PC.
